// File: rtl/cmac_pkg.sv
// rtl/cmac_pkg.sv - shared types and default timing for the CMAC link watchdog
package cmac_pkg;

   typedef enum logic [1:0] {
      RESET_HOLD = 2'd0,
      WAIT_ALIGN = 2'd1,
      LINKED     = 2'd2
   } cmac_wd_state_t;

   // Defaults assume a 100 MHz init_clk.
   localparam int CMAC_RESET_CYCLES  = 1000;
   localparam int CMAC_ALIGN_TIMEOUT = 100_000_000;
   localparam int CMAC_STABLE_CYCLES = 1024;
   localparam int CMAC_CNT_W         = 16;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cmac_link_watchdog_sync.sv
// rtl/cmac_link_watchdog_sync.sv - two-flop level synchronizer, xpm_cdc_single style (SRC_INPUT_REG=0)
module cmac_link_watchdog_sync #(
   parameter int DEST_SYNC_FF = 2
) (
   input  logic dest_clk,
   input  logic dest_rstn,
   input  logic src_in,
   output logic dest_out
);

   logic [DEST_SYNC_FF-1:0] sync_q;

   always_ff @(posedge dest_clk or negedge dest_rstn) begin
      if (!dest_rstn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[DEST_SYNC_FF-2:0], src_in};
      end
   end

   assign dest_out = sync_q[DEST_SYNC_FF-1];

endmodule

// File: rtl/cmac_link_watchdog.sv
// rtl/cmac_link_watchdog.sv - CMAC bring-up supervisor: reset hold, alignment timeout, debounced link_up
// Optional drop statistics counter enabled by CMAC_WD_STATS_EN.
module cmac_link_watchdog
   import cmac_pkg::*;
#(
   parameter int RESET_CYCLES  = CMAC_RESET_CYCLES,
   parameter int ALIGN_TIMEOUT = CMAC_ALIGN_TIMEOUT,
   parameter int STABLE_CYCLES = CMAC_STABLE_CYCLES,
   parameter int CNT_W         = CMAC_CNT_W
) (
   input  logic             init_clk,
   input  logic             init_resetn,
   input  logic             rx_aligned,
   input  logic             force_reset,
   output logic             cmac_reset,
   output logic             link_up,
   output logic [CNT_W-1:0] retry_count,
   output logic [CNT_W-1:0] drop_count
);

   localparam int TW = $clog2(max3(RESET_CYCLES, ALIGN_TIMEOUT, STABLE_CYCLES)) + 1;
   localparam logic [TW-1:0] HOLD_LAST    = TW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ALIGN_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);

   cmac_wd_state_t   state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [TW-1:0]    stable_q, stable_d;
   logic [CNT_W-1:0] retry_q;
   logic             cmac_reset_q, link_up_q;
   logic             retry_inc, drop_inc;
   logic             aligned_s;

   cmac_link_watchdog_sync #(
      .DEST_SYNC_FF (2)
   ) u_sync (
      .dest_clk  (init_clk),
      .dest_rstn (init_resetn),
      .src_in    (rx_aligned),
      .dest_out  (aligned_s)
   );

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      stable_d  = stable_q;
      retry_inc = 1'b0;
      drop_inc  = 1'b0;
      if (force_reset) begin
         state_d  = RESET_HOLD;
         timer_d  = '0;
         stable_d = '0;
      end else begin
         case (state_q)
            RESET_HOLD: begin
               if (timer_q == HOLD_LAST) begin
                  state_d  = WAIT_ALIGN;
                  timer_d  = '0;
                  stable_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            WAIT_ALIGN: begin
               timer_d  = timer_q + 1'b1;
               stable_d = aligned_s ? stable_q + 1'b1 : '0;
               // Alignment completing on the timeout cycle counts as success.
               if (aligned_s && (stable_q == STABLE_LAST)) begin
                  state_d  = LINKED;
                  timer_d  = '0;
                  stable_d = '0;
               end else if (timer_q == TIMEOUT_LAST) begin
                  state_d   = RESET_HOLD;
                  timer_d   = '0;
                  stable_d  = '0;
                  retry_inc = 1'b1;
               end
            end
            LINKED: begin
               if (!aligned_s) begin
                  state_d  = WAIT_ALIGN;
                  timer_d  = '0;
                  stable_d = '0;
                  drop_inc = 1'b1;
               end
            end
            default: begin
               state_d  = RESET_HOLD;
               timer_d  = '0;
               stable_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge init_clk or negedge init_resetn) begin
      if (!init_resetn) begin
         state_q      <= RESET_HOLD;
         timer_q      <= '0;
         stable_q     <= '0;
         retry_q      <= '0;
         cmac_reset_q <= 1'b1;
         link_up_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         stable_q     <= stable_d;
         cmac_reset_q <= (state_d == RESET_HOLD);
         link_up_q    <= (state_d == LINKED);
         if (retry_inc && (retry_q != {CNT_W{1'b1}})) begin
            retry_q <= retry_q + 1'b1;
         end
      end
   end

`ifdef CMAC_WD_STATS_EN
   logic [CNT_W-1:0] drop_q;

   always_ff @(posedge init_clk or negedge init_resetn) begin
      if (!init_resetn) begin
         drop_q <= '0;
      end else if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
         drop_q <= drop_q + 1'b1;
      end
   end

   assign drop_count = drop_q;
`else
   logic unused_drop_inc;
   assign unused_drop_inc = drop_inc;
   assign drop_count      = '0;
`endif

   assign cmac_reset  = cmac_reset_q;
   assign link_up     = link_up_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_cmac_link_watchdog.sv
// tb/tb_cmac_link_watchdog.sv - self-checking bench for cmac_link_watchdog
module tb_cmac_link_watchdog;

   localparam int RC   = 4;
   localparam int SC   = 8;
   localparam int AT   = 64;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef CMAC_WD_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   localparam int S_HOLD = 0;
   localparam int S_WAIT = 1;
   localparam int S_LINK = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          rx = 1'b0;
   logic          fr = 1'b0;
   logic          cmac_reset;
   logic          link_up;
   logic [CW-1:0] retry_count;
   logic [CW-1:0] drop_count;

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model: remaining hold cycles, age in WAIT, length of current aligned run.
   int m_state, m_hold_left, m_age, m_run, m_retry, m_drop;
   bit m_s1, m_s2;

   typedef struct {
      bit rx;
      bit fr;
      int n;
      bit cmac;
      bit link;
      int retry;
      int drop;
   } vec_t;

   vec_t vecs[13];

   cmac_link_watchdog #(
      .RESET_CYCLES  (RC),
      .ALIGN_TIMEOUT (AT),
      .STABLE_CYCLES (SC),
      .CNT_W         (CW)
   ) dut (
      .init_clk    (clk),
      .init_resetn (rstn),
      .rx_aligned  (rx),
      .force_reset (fr),
      .cmac_reset  (cmac_reset),
      .link_up     (link_up),
      .retry_count (retry_count),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state     = S_HOLD;
      m_hold_left = RC;
      m_age       = 0;
      m_run       = 0;
      m_retry     = 0;
      m_drop      = 0;
      m_s1        = 1'b0;
      m_s2        = 1'b0;
   endtask

   task automatic model_step(input bit a_in, input bit f);
      bit a;
      a    = m_s2;
      m_s2 = m_s1;
      m_s1 = a_in;
      if (f) begin
         m_state     = S_HOLD;
         m_hold_left = RC;
      end else if (m_state == S_HOLD) begin
         m_hold_left = m_hold_left - 1;
         if (m_hold_left == 0) begin
            m_state = S_WAIT;
            m_age   = 0;
            m_run   = 0;
         end
      end else if (m_state == S_WAIT) begin
         if (a && (m_run + 1 == SC)) begin
            m_state = S_LINK;
         end else if (m_age + 1 == AT) begin
            m_state     = S_HOLD;
            m_hold_left = RC;
            if (m_retry < CMAX) m_retry++;
         end else begin
            m_age++;
            m_run = a ? m_run + 1 : 0;
         end
      end else begin
         if (!a) begin
            m_state = S_WAIT;
            m_age   = 0;
            m_run   = 0;
            if (STATS != 0 && m_drop < CMAX) m_drop++;
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_model(input string tag);
      check({tag, " cmac_reset"}, int'(cmac_reset), int'(m_state == S_HOLD));
      check({tag, " link_up"}, int'(link_up), int'(m_state == S_LINK));
      check({tag, " retry_count"}, int'(retry_count), m_retry);
      check({tag, " drop_count"}, int'(drop_count), m_drop);
   endtask

   task automatic cycle(input bit a, input bit f, input bit cmp, input string tag);
      rx = a;
      fr = f;
      @(posedge clk);
      #1;
      model_step(a, f);
      @(negedge clk);
      if (cmp) check_model(tag);
   endtask

   initial begin
      bit link_seen;
      int run_left;
      bit rv;

      vecs[0]  = '{1, 0, 3, 1, 0, 0, 0};
      vecs[1]  = '{1, 0, 1, 0, 0, 0, 0};
      vecs[2]  = '{1, 0, 7, 0, 0, 0, 0};
      vecs[3]  = '{1, 0, 1, 0, 1, 0, 0};
      vecs[4]  = '{0, 0, 1, 0, 1, 0, 0};
      vecs[5]  = '{1, 0, 1, 0, 1, 0, 0};
      vecs[6]  = '{1, 0, 1, 0, 0, 0, STATS};
      vecs[7]  = '{1, 0, 7, 0, 0, 0, STATS};
      vecs[8]  = '{1, 0, 1, 0, 1, 0, STATS};
      vecs[9]  = '{1, 1, 1, 1, 0, 0, STATS};
      vecs[10] = '{1, 0, 3, 1, 0, 0, STATS};
      vecs[11] = '{1, 0, 1, 0, 0, 0, STATS};
      vecs[12] = '{1, 0, 8, 0, 1, 0, STATS};

      // Reset state, with rx_aligned already high
      rx = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset cmac_reset", int'(cmac_reset), 1);
      check("reset link_up", int'(link_up), 0);
      check("reset retry_count", int'(retry_count), 0);
      check("reset drop_count", int'(drop_count), 0);
      rstn = 1'b1;

      // Bring-up, single-cycle drop, relink, force_reset in LINKED
      for (int v = 0; v < 13; v++) begin
         for (int k = 0; k < vecs[v].n; k++) cycle(vecs[v].rx, vecs[v].fr, 1'b0, "vec");
         check($sformatf("vec%0d cmac_reset", v), int'(cmac_reset), int'(vecs[v].cmac));
         check($sformatf("vec%0d link_up", v), int'(link_up), int'(vecs[v].link));
         check($sformatf("vec%0d retry_count", v), int'(retry_count), vecs[v].retry);
         check($sformatf("vec%0d drop_count", v), int'(drop_count), vecs[v].drop);
      end

      // rx_aligned toggling every 5 cycles never debounces, times out once
      link_seen = 1'b0;
      cycle(1'b1, 1'b1, 1'b1, "toggle");
      for (int i = 0; i < RC + AT + 2; i++) begin
         cycle(((i / 5) % 2) == 0, 1'b0, 1'b1, "toggle");
         if (link_up) link_seen = 1'b1;
      end
      check("toggle link never up", int'(link_seen), 0);
      check("toggle retry_count", int'(retry_count), 1);

      // force_reset on the exact timeout cycle: no retry, full hold
      for (int i = 0; i < 2 + AT - 1; i++) cycle(1'b0, 1'b0, 1'b1, "pre-timeout");
      cycle(1'b0, 1'b1, 1'b1, "force at timeout");
      check("force at timeout retry_count", int'(retry_count), 1);
      check("force at timeout cmac_reset", int'(cmac_reset), 1);
      for (int i = 0; i < RC - 1; i++) cycle(1'b0, 1'b0, 1'b1, "force hold");
      check("force hold still high", int'(cmac_reset), 1);
      cycle(1'b0, 1'b0, 1'b1, "force hold end");
      check("force hold released", int'(cmac_reset), 0);

      // Repeated timeouts saturate retry_count
      for (int i = 0; i < 16 * (RC + AT); i++) cycle(1'b0, 1'b0, 1'b1, "retry");
      check("retry saturated", int'(retry_count), CMAX);

      // Randomized runs of rx_aligned with occasional force_reset
      run_left = 0;
      rv = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (run_left == 0) begin
            rv = $urandom_range(0, 1) == 1;
            run_left = $urandom_range(1, 24);
         end
         run_left--;
         cycle(rv, $urandom_range(0, 99) == 0, 1'b1, "random");
      end

      // Asynchronous reset during WAIT_ALIGN
      cycle(1'b0, 1'b1, 1'b1, "pre-reset");
      for (int i = 0; i < RC + 2; i++) cycle(1'b0, 1'b0, 1'b1, "pre-reset");
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      check("async reset cmac_reset", int'(cmac_reset), 1);
      check("async reset link_up", int'(link_up), 0);
      check("async reset retry_count", int'(retry_count), 0);
      check("async reset drop_count", int'(drop_count), 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < RC + SC + 8; i++) cycle(1'b1, 1'b0, 1'b1, "rebringup");
      check("rebringup link_up", int'(link_up), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
